// File: rtl/rstack_pkg.sv
// Shared constants and operation encoding for the return-address stack.
// Optional feature macro: RSTACK_UNDERFLOW_EN (see return_stack.sv).
package rstack_pkg;

    localparam int RSTACK_WIDTH = 12;
    localparam int RSTACK_DEPTH = 8;

    // Operation encoding is the concatenation {push, pop}.
    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } op_t;

endpackage

// File: rtl/return_stack_if.sv
// Datapath <-> return-stack signal bundle. The datapath is the master
// (drives the strobes), the stack is the slave (drives status and top).
interface return_stack_if #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 4
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] top;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, push_data,
        input  top, count, full, empty, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data,
        output top, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/rstack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module rstack_mem #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Write the addressed entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/return_stack.sv
// Hardware return-address stack. Push stores a return address, pop
// discards the top; push+pop replaces the top in place. The top entry is
// presented combinationally so a pop can load pc on the same edge.
// Optional feature macro: RSTACK_UNDERFLOW_EN -- when defined, a sticky
// underflow flag records pops issued while empty; otherwise underflow is 0.
module return_stack
    import rstack_pkg::*;
#(
    parameter int WIDTH = RSTACK_WIDTH,
    parameter int DEPTH = RSTACK_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    return_stack_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    op_t              op;
    logic [CNT_W-1:0] sp;
    logic [CNT_W-1:0] sp_nxt;
    logic             is_full;
    logic             is_empty;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] rd_data;
    logic             ovf_q;
    logic             ovf_set;

    assign op       = op_t'({bus.push, bus.pop});
    assign is_full  = (sp == CNT_W'(DEPTH));
    assign is_empty = (sp == '0);
    assign top_addr = AW'(sp - CNT_W'(1));

    // Decode the strobes into a write and the next stack pointer.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = AW'(sp);
        sp_nxt   = sp;
        ovf_set  = 1'b0;
        case (op)
            OP_PUSH: begin
                // A full stack keeps its entries; nothing wraps or drops.
                if (!is_full) begin
                    mem_we = 1'b1;
                    sp_nxt = sp + CNT_W'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end
            OP_POP: begin
                if (!is_empty) sp_nxt = sp - CNT_W'(1);
            end
            OP_REPLACE: begin
                // On an empty stack this degenerates to a plain push.
                mem_we = 1'b1;
                if (is_empty) begin
                    mem_addr = '0;
                    sp_nxt   = CNT_W'(1);
                end else begin
                    mem_addr = top_addr;
                end
            end
            default: ;
        endcase
    end

    // Stack pointer and sticky overflow; reset empties the stack at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            ovf_q <= 1'b0;
        end else begin
            sp <= sp_nxt;
            if (ovf_set) ovf_q <= 1'b1;
        end
    end

`ifdef RSTACK_UNDERFLOW_EN
    logic udf_q;
    logic udf_set;

    assign udf_set = (op == OP_POP) && is_empty;

    // Sticky underflow: set by a pop-only while empty, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          udf_q <= 1'b0;
        else if (udf_set) udf_q <= 1'b1;
    end

    assign bus.underflow = udf_q;
`else
    assign bus.underflow = 1'b0;
`endif

    rstack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (mem_addr),
        .wr_data (bus.push_data),
        .rd_addr (top_addr),
        .rd_data (rd_data)
    );

    assign bus.top      = is_empty ? '0 : rd_data;
    assign bus.count    = sp;
    assign bus.full     = is_full;
    assign bus.empty    = is_empty;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: a queue-based reference model checked
// against the outputs every negedge, plus hand-computed literal checks.
module tb_return_stack;
    import rstack_pkg::*;

    localparam int W = RSTACK_WIDTH;
    localparam int D = RSTACK_DEPTH;
    localparam int C = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    return_stack_if #(.WIDTH(W), .CNT_W(C)) bus ();

    return_stack #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

`ifdef RSTACK_UNDERFLOW_EN
    localparam bit UDF_ON = 1'b1;
`else
    localparam bit UDF_ON = 1'b0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue whose back is the top of stack.
    int m_q[$];
    bit m_ovf, m_udf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            if (bus.push && bus.pop) begin
                if (m_q.size() > 0) m_q[m_q.size()-1] = int'(bus.push_data);
                else                m_q.push_back(int'(bus.push_data));
            end else if (bus.push) begin
                if (m_q.size() < D) m_q.push_back(int'(bus.push_data));
                else                m_ovf = 1;
            end else if (bus.pop) begin
                if (m_q.size() > 0) void'(m_q.pop_back());
                else if (UDF_ON)    m_udf = 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model.top",   int'(bus.top),   (m_q.size() > 0) ? m_q[m_q.size()-1] : 0);
            chk("model.count", int'(bus.count), m_q.size());
            chk("model.full",  int'(bus.full),  int'(m_q.size() == D));
            chk("model.empty", int'(bus.empty), int'(m_q.size() == 0));
            chk("model.ovf",   int'(bus.overflow),  int'(m_ovf));
            chk("model.udf",   int'(bus.underflow), int'(m_udf));
        end
    end

    // Set strobes, then advance one edge (returns #1 after the edge).
    task automatic drive(input op_t op, input logic [W-1:0] d);
        {bus.push, bus.pop} = op;
        bus.push_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {bus.push, bus.pop} = OP_NONE;
        bus.push_data = '0;
    endtask

    task automatic reset_pulse();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        idle();
        #1;
        // Reset state
        chk("rst.count", int'(bus.count), 0);
        chk("rst.empty", int'(bus.empty), 1);
        chk("rst.top",   int'(bus.top),   0);
        chk("rst.ovf",   int'(bus.overflow),  0);
        chk("rst.udf",   int'(bus.underflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Three pushes
        drive(OP_PUSH, 12'h005);
        drive(OP_PUSH, 12'h010);
        drive(OP_PUSH, 12'h1FF);
        idle();
        chk("push3.count", int'(bus.count), 3);
        chk("push3.top",   int'(bus.top),   'h1FF);

        // Pops read old top before the edge
        {bus.push, bus.pop} = OP_POP; #1;
        chk("pop1.top", int'(bus.top), 'h1FF);
        @(posedge clk); #1;
        chk("pop2.top", int'(bus.top), 'h010);
        @(posedge clk); #1;
        chk("pop3.top", int'(bus.top), 'h005);
        @(posedge clk); #1;
        idle();
        chk("pop3.empty", int'(bus.empty), 1);
        chk("pop3.topz",  int'(bus.top),   0);

        // Fill, overflow, drain
        for (int i = 0; i < D; i++) drive(OP_PUSH, W'(12'h100 + i));
        idle();
        chk("fill.full", int'(bus.full), 1);
        drive(OP_PUSH, 12'hABC);
        idle();
        chk("ovf.flag",  int'(bus.overflow), 1);
        chk("ovf.count", int'(bus.count), 8);
        chk("ovf.top",   int'(bus.top),   'h107);
        {bus.push, bus.pop} = OP_POP;
        for (int i = 0; i < D; i++) begin
            #1;
            chk("drain.top", int'(bus.top), 'h107 - i);
            @(posedge clk); #1;
        end
        idle();
        chk("drain.empty", int'(bus.empty), 1);

        // Replace-top, clear flags first
        reset_pulse();
        drive(OP_PUSH, 12'h010);
        drive(OP_PUSH, 12'h020);
        idle();
        chk("rep.pre.top", int'(bus.top), 'h020);
        drive(OP_REPLACE, 12'h3C3);
        idle();
        chk("rep.count", int'(bus.count), 2);
        chk("rep.top",   int'(bus.top),   'h3C3);
        chk("rep.ovf",   int'(bus.overflow),  0);
        chk("rep.udf",   int'(bus.underflow), 0);
        // Replace while full raises no overflow
        for (int i = 2; i < D; i++) drive(OP_PUSH, W'(12'h200 + i));
        drive(OP_REPLACE, 12'h777);
        idle();
        chk("repfull.count", int'(bus.count), 8);
        chk("repfull.top",   int'(bus.top),   'h777);
        chk("repfull.ovf",   int'(bus.overflow), 0);
        for (int i = 0; i < D; i++) drive(OP_POP, '0);
        // Replace on empty acts as push
        drive(OP_REPLACE, 12'h3C3);
        idle();
        chk("repempty.count", int'(bus.count), 1);
        chk("repempty.top",   int'(bus.top),   'h3C3);
        chk("repempty.udf",   int'(bus.underflow), 0);
        drive(OP_POP, '0);

        // Pop while empty
        drive(OP_POP, '0);
        idle();
        chk("udf.flag",  int'(bus.underflow), int'(UDF_ON));
        chk("udf.count", int'(bus.count), 0);
        drive(OP_PUSH, 12'h001);
        idle();
        chk("udf.sticky", int'(bus.underflow), int'(UDF_ON));
        drive(OP_POP, '0);

        // Async reset between edges (overflow set first so the clear shows)
        for (int i = 0; i < D; i++) drive(OP_PUSH, W'(i));
        drive(OP_PUSH, 12'hFFF);
        for (int i = 0; i < D; i++) drive(OP_POP, '0);
        drive(OP_PUSH, 12'h00A);
        drive(OP_PUSH, 12'h00B);
        idle();
        chk("arst.pre.count", int'(bus.count), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.count", int'(bus.count), 0);
        chk("arst.empty", int'(bus.empty), 1);
        chk("arst.top",   int'(bus.top),   0);
        chk("arst.ovf",   int'(bus.overflow),  0);
        chk("arst.udf",   int'(bus.underflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        d = 12'h00C;
        drive(OP_PUSH, d);
        idle();
        chk("post.top",   int'(bus.top),   'h00C);
        chk("post.count", int'(bus.count), 1);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
